// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants, field widths and small decode helpers
// used by the pipeline-register slice.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_J     = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // True when the instruction reads rt as a source operand (not a destination).
    function automatic logic uses_rt(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads the
// register that the load currently in ID/EX is about to write.
module hazard_detect
    import mips_pkg::*;
(
    input  logic             valid_i,
    input  logic [OP_W-1:0]  opcode_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    output logic             hazard_o
);

    logic rs_hit;
    logic rt_hit;

    // $zero is never a real dependency, so a load into r0 cannot stall.
    assign rs_hit   = (idex_rt_i == rs_i);
    assign rt_hit   = uses_rt(opcode_i) && (idex_rt_i == rt_i);
    assign hazard_o = valid_i && idex_memread_i && (idex_rt_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch squash, jump
// self-squash and saturating stall/flush event counters.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter logic [5:0]  JUMP_OP = 6'd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_add_4_i,
    input  logic             flush_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    output logic [31:0]      instr_o,
    output logic [31:0]      pc_add_4_o,
    output logic             valid_o,
    output logic [5:0]       opcode_o,
    output logic [4:0]       rs_o,
    output logic [4:0]       rt_o,
    output logic [4:0]       rd_o,
    output logic [5:0]       funct_o,
    output logic [15:0]      imm_o,
    output logic [31:0]      jumpaddr_o,
    output logic             jump_o,
    output logic             pc_write_o,
    output logic             bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             hazard;
    logic             hz;

    assign instr_o     = instr_q;
    assign pc_add_4_o  = pc_q;
    assign valid_o     = valid_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

    // Decode fields are plain slices of the held instruction.
    assign opcode_o   = instr_q[31:26];
    assign rs_o       = instr_q[25:21];
    assign rt_o       = instr_q[20:16];
    assign rd_o       = instr_q[15:11];
    assign funct_o    = instr_q[5:0];
    assign imm_o      = instr_q[15:0];
    assign jumpaddr_o = {pc_q[31:28], instr_q[25:0], 2'b00};
    assign jump_o     = valid_q && (instr_q[31:26] == JUMP_OP);

    hazard_detect u_hazard_detect (
        .valid_i        (valid_q),
        .opcode_i       (instr_q[31:26]),
        .rs_i           (instr_q[25:21]),
        .rt_i           (instr_q[20:16]),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .hazard_o       (hazard)
    );

    // A redirect overrides the stall: the dependent instruction is on the wrong path.
    assign hz         = hazard && !flush_i;
    assign pc_write_o = !hz;
    assign bubble_o   = hz;

    // Next-state selection in priority order: flush, stall, jump squash, load.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (flush_i) begin
            instr_d = NOP;
            pc_d    = '0;
            valid_d = 1'b0;
            if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
        end else if (hz) begin
            if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        end else if (jump_o) begin
            // Drop the sequentially fetched slot behind a j; keep its PC+4 for debug.
            instr_d = NOP;
            pc_d    = pc_add_4_i;
            valid_d = 1'b0;
        end else begin
            instr_d = instr_i;
            pc_d    = pc_add_4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP;
            pc_q    <= '0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a behavioural model predicts each
// registered state, queues it at drive time and compares after the edge.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_i;
    logic [31:0] pc_add_4_i;
    logic        flush_i;
    logic        idex_memread_i;
    logic [4:0]  idex_rt_i;
    logic [31:0] instr_o;
    logic [31:0] pc_add_4_o;
    logic        valid_o;
    logic [5:0]  opcode_o;
    logic [4:0]  rs_o;
    logic [4:0]  rt_o;
    logic [4:0]  rd_o;
    logic [5:0]  funct_o;
    logic [15:0] imm_o;
    logic [31:0] jumpaddr_o;
    logic        jump_o;
    logic        pc_write_o;
    logic        bubble_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    if_id_stage #(.CNT_W(16), .JUMP_OP(6'd2)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_i        (instr_i),
        .pc_add_4_i     (pc_add_4_i),
        .flush_i        (flush_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .instr_o        (instr_o),
        .pc_add_4_o     (pc_add_4_o),
        .valid_o        (valid_o),
        .opcode_o       (opcode_o),
        .rs_o           (rs_o),
        .rt_o           (rt_o),
        .rd_o           (rd_o),
        .funct_o        (funct_o),
        .imm_o          (imm_o),
        .jumpaddr_o     (jumpaddr_o),
        .jump_o         (jump_o),
        .pc_write_o     (pc_write_o),
        .bubble_o       (bubble_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [15:0] m_sc;
    logic [15:0] m_fc;
    logic        m_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_hz(input logic fl, input logic mr, input logic [4:0] lrt);
        logic [5:0] op;
        logic       src_rt;
        op     = m_instr[31:26];
        src_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
        if (!m_valid || !mr || fl || lrt == 5'd0) return 1'b0;
        return (lrt == m_instr[25:21]) || (src_rt && lrt == m_instr[20:16]);
    endfunction

    // One clock: drive, check combinational outputs, predict, then compare after the edge.
    task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] pc4,
                         input logic fl, input logic mr, input logic [4:0] lrt);
        exp_t e;
        logic hzm;
        logic jm;
        rst            = r;
        instr_i        = ins;
        pc_add_4_i     = pc4;
        flush_i        = fl;
        idex_memread_i = mr;
        idex_rt_i      = lrt;
        #2;
        hzm = model_hz(fl, mr, lrt);
        jm  = m_valid && (m_instr[31:26] == 6'd2);
        if (m_known) begin
            check("bubble", 32'(bubble_o), 32'(hzm));
            check("pc_write", 32'(pc_write_o), 32'(!hzm));
            check("jump", 32'(jump_o), 32'(jm));
            check("jumpaddr", jumpaddr_o, {m_pc[31:28], m_instr[25:0], 2'b00});
        end
        if (r) begin
            m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_sc = 16'h0; m_fc = 16'h0;
            m_known = 1'b1;
        end else if (fl) begin
            m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end else if (hzm) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        end else if (jm) begin
            m_instr = 32'h0; m_pc = pc4; m_valid = 1'b0;
        end else begin
            m_instr = ins; m_pc = pc4; m_valid = 1'b1;
        end
        e.instr = m_instr; e.pc = m_pc; e.valid = m_valid; e.sc = m_sc; e.fc = m_fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("instr", instr_o, e.instr);
            check("pc_add_4", pc_add_4_o, e.pc);
            check("valid", 32'(valid_o), 32'(e.valid));
            check("stall_cnt", 32'(stall_cnt_o), 32'(e.sc));
            check("flush_cnt", 32'(flush_cnt_o), 32'(e.fc));
            check("fields", {opcode_o, rs_o, rt_o, rd_o, funct_o[5:0]},
                  {e.instr[31:11], e.instr[5:0]});
            check("imm", 32'(imm_o), 32'(e.instr[15:0]));
        end
    endtask

    localparam logic [31:0] ADD_I = 32'h012A4020;
    localparam logic [31:0] LW_I  = 32'h8D2A0000;
    localparam logic [31:0] J_I   = 32'h08000010;

    initial begin
        logic [5:0]  ops[6];
        logic [31:0] ri;
        ops[0] = 6'd0; ops[1] = 6'd2; ops[2] = 6'd4; ops[3] = 6'd35; ops[4] = 6'd43; ops[5] = 6'd8;
        rst = 1'b1; instr_i = '0; pc_add_4_i = '0; flush_i = 1'b0;
        idex_memread_i = 1'b0; idex_rt_i = '0;
        @(posedge clk); #1;

        cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        check("reset_instr", instr_o, 32'h0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_pc_write", 32'(pc_write_o), 32'd1);
        check("reset_bubble", 32'(bubble_o), 32'd0);

        // Capture of add $8,$9,$10.
        cycle(1'b0, ADD_I, 32'd4, 1'b0, 1'b0, 5'd0);
        check("add_instr", instr_o, ADD_I);
        check("add_rs", 32'(rs_o), 32'd9);
        check("add_rt", 32'(rt_o), 32'd10);
        check("add_rd", 32'(rd_o), 32'd8);
        check("add_funct", 32'(funct_o), 32'd32);
        check("add_valid", 32'(valid_o), 32'd1);

        // Load-use on rs: one-cycle stall, then the lw enters.
        cycle(1'b0, LW_I, 32'd8, 1'b0, 1'b1, 5'd9);
        check("stall_held", instr_o, ADD_I);
        check("stall_cnt_1", 32'(stall_cnt_o), 32'd1);
        cycle(1'b0, LW_I, 32'd8, 1'b0, 1'b0, 5'd9);
        check("after_stall", instr_o, LW_I);

        // lw's rt is a destination, and r0 never stalls.
        cycle(1'b0, ADD_I, 32'd12, 1'b0, 1'b1, 5'd10);
        cycle(1'b0, ADD_I, 32'd16, 1'b0, 1'b1, 5'd0);

        // Flush against a live hazard.
        cycle(1'b0, LW_I, 32'd20, 1'b1, 1'b1, 5'd9);
        check("flush_instr", instr_o, 32'h0);
        check("flush_cnt_1", 32'(flush_cnt_o), 32'd1);
        check("flush_stall_kept", 32'(stall_cnt_o), 32'd1);

        // Jump self-squash.
        cycle(1'b0, J_I, 32'h00400008, 1'b0, 1'b0, 5'd0);
        check("j_jump", 32'(jump_o), 32'd1);
        check("j_addr", jumpaddr_o, 32'h00000040);
        cycle(1'b0, ADD_I, 32'h0040000C, 1'b0, 1'b0, 5'd0);
        check("j_squash_instr", instr_o, 32'h0);
        check("j_squash_valid", 32'(valid_o), 32'd0);

        // Mixed random traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            ri = {ops[$urandom_range(5, 0)], 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                  16'($urandom)};
            cycle(1'b0, ri, 32'($urandom), ($urandom_range(9, 0) == 0),
                  ($urandom_range(1, 0) == 1), 5'($urandom_range(3, 0)));
        end

        // Counter saturation under a held hazard.
        cycle(1'b0, ADD_I, 32'd4, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 65540; i++) cycle(1'b0, LW_I, 32'd8, 1'b0, 1'b1, 5'd9);
        check("stall_sat", 32'(stall_cnt_o), 32'h0000FFFF);
        for (int i = 0; i < 3; i++) cycle(1'b0, LW_I, 32'd8, 1'b0, 1'b1, 5'd9);
        check("stall_sat_hold", 32'(stall_cnt_o), 32'h0000FFFF);

        // Reset in the middle of the stall.
        cycle(1'b1, LW_I, 32'd8, 1'b0, 1'b1, 5'd9);
        check("rst_mid_instr", instr_o, 32'h0);
        check("rst_mid_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("rst_mid_pc_write", 32'(pc_write_o), 32'd1);
        check("rst_mid_bubble", 32'(bubble_o), 32'd0);
        cycle(1'b0, ADD_I, 32'd4, 1'b0, 1'b0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
